conv_adder_scheduler: RTL
=========================

Name: conv_adder_scheduler

Overview:
- Shares one param_int_adder instance between NUM_REQ convolution channel engines.
- Each engine presents a NUM_INPUTS-wide vector of products per pass. A round-robin arbiter grants one requester per cycle and drives the adder.
- A tag pipeline tracks the adder latency. Per-requester 32-bit accumulators sum the partial results across passes (input channels).
- When the requester's last pass completes, the block emits one tagged final sum.

Parameters:
- DATA_WIDTH, 32, width of each product element (signed).
- NUM_INPUTS, 9, elements per vector (kernel window size).
- NUM_REQ, 4, number of requesters; must be >=2.
- ADDER_LAT, 1, cycles from add asserted at the adder to valid out of the adder.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until granted.
- req_last  in  NUM_REQ  marks the requester's current vector as the final pass of its window.
- req_data  in  NUM_REQ*NUM_INPUTS*DATA_WIDTH  requester r occupies slice r.
- gnt  out  NUM_REQ  one-hot combinational grant; the vector is consumed in this cycle.
- add  out  1  registered strobe to the adder.
- add_data  out  NUM_INPUTS*DATA_WIDTH  registered vector to the adder.
- add_sum  in  32  adder out_data.
- add_valid  in  1  adder valid.
- res_valid  out  1  single-cycle final-result strobe.
- res_id  out  ID_W  requester index of the result, where ID_W = clog2(NUM_REQ).
- res_data  out  32  final accumulated sum, signed.

Behaviour:
- Reset:
  - add=0, add_data=0, res_valid=0, res_id=0, res_data=0.
  - All accumulators=0; all active bits=0; rr pointer=0; tag pipeline valid bits=0.
  - gnt=0 while rst is high.
- Arbitration:
  - Round robin starting at the pointer. gnt is the first asserted req at or after the pointer, wrapping.
  - On a grant, pointer <= granted index+1 (mod NUM_REQ). With no request, the pointer holds.
  - At most one grant per cycle. The adder never stalls, so any pending request is granted within NUM_REQ cycles.
- Issue stage:
  - Cycle T has gnt[r]=1. At T+1: add=1, add_data=slice r, tag {r, req_last[r]} enters the tag pipe.
  - With no grant, add=0 and add_data holds its previous value.
- Tag pipe:
  - ADDER_LAT stages, in order, aligned so the tag exits in the same cycle as add_valid.
  - add_valid without a matching tag valid is a protocol error: ignored, and the accumulator is unchanged.
- Accumulate, on add_valid with tag {r, last}:
  - sum = (active[r] ? acc[r] : 0) + signed add_sum, modulo 2^32 (wrap).
  - If last=0: acc[r] <= sum, active[r] <= 1.
  - If last=1: res_valid=1, res_id=r, res_data=sum (registered, next cycle); acc[r] <= 0, active[r] <= 0.
- Result latency, last pass: grant at T -> add at T+1 -> add_valid at T+1+ADDER_LAT -> res_valid at T+2+ADDER_LAT.
- Back-to-back passes from one requester are legal while earlier ones are in flight. In-order delivery keeps the accumulation correct.
- Single-pass window (req_last=1 on the first vector): res_data = that vector's sum.
- Different requesters finishing in consecutive cycles give consecutive res_valid pulses, in arbitration order.
- Reset mid-operation: in-flight tags are discarded and partial sums are lost. Adder outputs returning after reset are ignored because the tag valid is 0.

Optional Feature:
- Macro: CONV_SCHED_SAT_EN.
- Defined: accumulation saturates to the signed 32-bit range. Overflow clamps to 32'h7FFFFFFF and underflow to 32'h80000000; a clamped value persists as the base for subsequent passes.
- Undefined: wrap modulo 2^32 as above.

Decomposition:
- Package conv_sched_pkg:
  - SUM_W=32.
  - SAT_MAX, SAT_MIN constants.
  - clog2 function for ID_W.
  - typedef for the tag struct {id, last, valid}.
- One sub-module: conv_rr_arbiter.
  - Parameterised NUM_REQ; ports req, advance, gnt.
  - Owns the pointer register and the same synchronous reset.

Test Plan:
- Single requester, 3 passes with vector sums 10, -4, 7, last on the third -> exactly one res_valid, res_id=0, res_data=13, ADDER_LAT+2 cycles after the third grant.
- All 4 requesting continuously from reset -> grants 0,1,2,3,0,... with no gaps and no double grants. Holding only req[2] and req[0] -> grants alternate 2,0.
- Two requesters interleaved (r1 sums 5,5,last; r3 sums 100,last) -> res r3=100 and r1=10, each tagged correctly, order matching the last-grant order.
- Single-pass window, sum 0x7FFFFFFF then a new 2-pass window 0x7FFFFFFF + 1 -> 0x7FFFFFFF, then 0x80000000 wrap. With CONV_SCHED_SAT_EN -> 0x7FFFFFFF both times.
- Assert rst for 1 cycle while 2 passes are in flight -> no res_valid afterward, and the next window starts from 0. Pointer back to 0, so grant order restarts at requester 0.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution adder scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: sum width, saturation bounds, a constant clog2 for sizing the
// requester id, and the tag that travels alongside a vector through the adder.
package conv_sched_pkg;

    localparam int SUM_W = 32;
    localparam logic [SUM_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [SUM_W-1:0] SAT_MIN = 32'h8000_0000;

    // Tag id field is sized for up to 256 requesters; the top narrows it.
    localparam int TAG_ID_W = 8;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        logic                last;
        logic                valid;
    } tag_t;

endpackage

// File: rtl/conv_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at/after the pointer.
// Latency: combinational grant; pointer updates on the clock edge after a grant.
// Backpressure: advance=0 freezes the pointer; grant still reflects requests.
//
// Ports: clk, rst (sync, active-high), req[NUM_REQ], advance, gnt[NUM_REQ].
// gnt is forced to zero while rst is high.
module conv_rr_arbiter
    import conv_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    always_comb begin : arb_comb
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        ptr_d = ptr_q;
        if (!rst) begin
            // Scan NUM_REQ positions starting at the pointer, wrapping.
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = (int'(ptr_q) + i) % NUM_REQ;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    if (advance) ptr_d = ID_W'((idx + 1) % NUM_REQ);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/conv_adder_scheduler.sv
// Shares one vector adder among NUM_REQ engines and accumulates per-requester sums.
// Latency: grant T -> add T+1 -> add_valid T+1+ADDER_LAT -> res_valid T+2+ADDER_LAT.
// Backpressure: none downstream; a held req is granted within NUM_REQ cycles.
//
// Ports: req/req_last/req_data from engines, gnt back to them; add/add_data to
// the adder, add_sum/add_valid from it; res_valid/res_id/res_data final sums.
// Build option: CONV_SCHED_SAT_EN makes accumulation saturate instead of wrap.
module conv_adder_scheduler
    import conv_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 9,
    parameter int NUM_REQ    = 4,
    parameter int ADDER_LAT  = 1,
    localparam int ID_W      = clog2(NUM_REQ),
    localparam int VEC_W     = NUM_INPUTS * DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*VEC_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     add,
    output logic [VEC_W-1:0]         add_data,
    input  logic [SUM_W-1:0]         add_sum,
    input  logic                     add_valid,
    output logic                     res_valid,
    output logic [ID_W-1:0]          res_id,
    output logic [SUM_W-1:0]         res_data
);

    // The adder never stalls, so the pointer may advance on every grant.
    conv_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (1'b1),
        .gnt     (gnt)
    );

    // ---------------- issue stage ----------------
    logic [ID_W-1:0]  gnt_id;
    logic             add_q, add_d;
    logic [VEC_W-1:0] add_data_q, add_data_d;
    tag_t             issue_tag_q, issue_tag_d;

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_id = ID_W'(i);
        end
    end

    always_comb begin
        add_d       = |gnt;
        add_data_d  = add_data_q;
        issue_tag_d = '0;
        if (|gnt) begin
            add_data_d        = req_data[int'(gnt_id)*VEC_W +: VEC_W];
            issue_tag_d.id    = TAG_ID_W'(gnt_id);
            issue_tag_d.last  = req_last[gnt_id];
            issue_tag_d.valid = 1'b1;
        end
    end

    // ---------------- tag pipe ----------------
    // Issue register covers the add strobe cycle; ADDER_LAT more stages line
    // the tag up with add_valid.
    tag_t tag_pipe_q [ADDER_LAT];
    tag_t tag_pipe_d [ADDER_LAT];

    always_comb begin
        tag_pipe_d    = tag_pipe_q;
        tag_pipe_d[0] = issue_tag_q;
        for (int k = 1; k < ADDER_LAT; k++) tag_pipe_d[k] = tag_pipe_q[k-1];
    end

    tag_t            exit_tag;
    logic [ID_W-1:0] exit_id;
    logic            tag_ok;

    assign exit_tag = tag_pipe_q[ADDER_LAT-1];
    assign exit_id  = exit_tag.id[ID_W-1:0];
    // Out-of-range ids are treated like a missing tag rather than indexing past the array.
    assign tag_ok   = exit_tag.valid && (int'(exit_tag.id) < NUM_REQ);

    // ---------------- accumulate ----------------
    logic [SUM_W-1:0]   acc_q [NUM_REQ];
    logic [SUM_W-1:0]   acc_d [NUM_REQ];
    logic [NUM_REQ-1:0] active_q, active_d;
    logic               res_valid_q, res_valid_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic [SUM_W-1:0]   res_data_q, res_data_d;
    logic [SUM_W-1:0]   base, sum;

    // A fresh window starts from zero regardless of any stale accumulator.
    assign base = active_q[exit_id] ? acc_q[exit_id] : '0;

`ifdef CONV_SCHED_SAT_EN
    logic [SUM_W:0] sum_wide;
    assign sum_wide = {base[SUM_W-1], base} + {add_sum[SUM_W-1], add_sum};
    always_comb begin
        sum = sum_wide[SUM_W-1:0];
        // Top two bits disagree only when the signed result left 32-bit range.
        if (sum_wide[SUM_W] != sum_wide[SUM_W-1])
            sum = sum_wide[SUM_W] ? SAT_MIN : SAT_MAX;
    end
`else
    assign sum = base + add_sum;
`endif

    always_comb begin
        acc_d       = acc_q;
        active_d    = active_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        if (add_valid && tag_ok) begin
            if (exit_tag.last) begin
                res_valid_d       = 1'b1;
                res_id_d          = exit_id;
                res_data_d        = sum;
                acc_d[exit_id]    = '0;
                active_d[exit_id] = 1'b0;
            end else begin
                acc_d[exit_id]    = sum;
                active_d[exit_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_q       <= 1'b0;
            add_data_q  <= '0;
            issue_tag_q <= '0;
            for (int k = 0; k < ADDER_LAT; k++) tag_pipe_q[k] <= '0;
            for (int i = 0; i < NUM_REQ; i++) acc_q[i] <= '0;
            active_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            add_q       <= add_d;
            add_data_q  <= add_data_d;
            issue_tag_q <= issue_tag_d;
            tag_pipe_q  <= tag_pipe_d;
            acc_q       <= acc_d;
            active_q    <= active_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end

    assign add       = add_q;
    assign add_data  = add_data_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;

endmodule
